// File: rtl/pipeline_safety_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_safety_scheduler
// Description : Sequences core startup, periodic ALU BIST windows and
//               latching of fatal ECC / mux / BIST faults into a halt state.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_safety_scheduler #(
    parameter int BIST_PERIOD = 1024,
    parameter int BIST_LEN    = 16,
    parameter int SETTLE      = 4,
    parameter int CNT_W       = 8,
    parameter int SERR_LIMIT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loader_done_in,
    input  logic             hardware_fault_flag,
    input  logic             mux_error_flag,
    input  logic             s_err_imem,
    input  logic             s_err_dmem,
    input  logic             d_err_imem,
    input  logic             d_err_dmem,
    input  logic             clr_faults,
    output logic             core_run,
    output logic             test_en_out,
    output logic             halt,
    output logic [3:0]       fault_code,
    output logic [CNT_W-1:0] s_err_count,
    output logic [CNT_W-1:0] bist_pass_count
);

    localparam int c_win_w = (BIST_LEN > 2) ? $clog2(BIST_LEN) : 1;
    localparam int c_per_w = (BIST_PERIOD > 2) ? $clog2(BIST_PERIOD) : 1;

    localparam logic [c_win_w-1:0] c_win_last  = c_win_w'(BIST_LEN - 1);
    localparam logic [c_win_w-1:0] c_settle    = c_win_w'(SETTLE);
    localparam logic [c_per_w-1:0] c_per_last  = c_per_w'(BIST_PERIOD - 1);
    localparam logic [CNT_W-1:0]   c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   c_serr_lim  = CNT_W'(SERR_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIST = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [c_win_w-1:0]   r_win,   w_win_nx;
    logic [c_per_w-1:0]   r_per,   w_per_nx;
    logic [3:0]           r_code,  w_code_nx;
    logic [CNT_W-1:0]     r_serr,  w_serr_nx;
    logic [CNT_W-1:0]     r_pass,  w_pass_nx;
    logic                 r_core_run, r_test_en, r_halt;

    logic [1:0]           w_serr_inc;
    logic [CNT_W:0]       w_serr_sum;
    logic [CNT_W-1:0]     w_serr_sat;
    logic [3:0]           w_fatal;

    // Saturating single-error accumulation; the limit check uses the updated value.
    always_comb begin
        w_serr_inc = {1'b0, s_err_imem} + {1'b0, s_err_dmem};
        w_serr_sum = {1'b0, r_serr} + (CNT_W + 1)'(w_serr_inc);
        w_serr_sat = w_serr_sum[CNT_W] ? c_cnt_max : w_serr_sum[CNT_W-1:0];
    end

    // Lowest code wins when several fatal sources fire together.
    always_comb begin
        w_fatal = 4'd0;
        if (r_state == ST_BIST || r_state == ST_RUN) begin
            if (d_err_imem)
                w_fatal = 4'd1;
            else if (d_err_dmem)
                w_fatal = 4'd2;
            else if (mux_error_flag)
                w_fatal = 4'd3;
            else if (r_state == ST_BIST && hardware_fault_flag && r_win >= c_settle)
                w_fatal = 4'd4;
            else if (w_serr_sat >= c_serr_lim)
                w_fatal = 4'd5;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_win_nx   = r_win;
        w_per_nx   = r_per;
        w_code_nx  = r_code;
        w_serr_nx  = r_serr;
        w_pass_nx  = r_pass;
        case (r_state)
            ST_IDLE: begin
                if (loader_done_in) begin
                    w_state_nx = ST_BIST;
                    w_win_nx   = '0;
                end
            end
            ST_BIST: begin
                w_serr_nx = w_serr_sat;
                if (w_fatal != 4'd0) begin
                    w_state_nx = ST_HALT;
                    w_code_nx  = w_fatal;
                end else if (!loader_done_in) begin
                    w_state_nx = ST_IDLE;
                end else if (r_win == c_win_last) begin
                    w_state_nx = ST_RUN;
                    w_per_nx   = '0;
                    w_pass_nx  = r_pass + CNT_W'(1);
                end else begin
                    w_win_nx = r_win + c_win_w'(1);
                end
            end
            ST_RUN: begin
                w_serr_nx = w_serr_sat;
                if (w_fatal != 4'd0) begin
                    w_state_nx = ST_HALT;
                    w_code_nx  = w_fatal;
                end else if (!loader_done_in) begin
                    w_state_nx = ST_IDLE;
                end else if (r_per == c_per_last) begin
                    w_state_nx = ST_BIST;
                    w_win_nx   = '0;
                end else begin
                    w_per_nx = r_per + c_per_w'(1);
                end
            end
            ST_HALT: begin
                if (clr_faults) begin
                    w_state_nx = ST_IDLE;
                    w_code_nx  = 4'd0;
                    w_serr_nx  = '0;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_win      <= '0;
            r_per      <= '0;
            r_code     <= 4'd0;
            r_serr     <= '0;
            r_pass     <= '0;
            r_core_run <= 1'b0;
            r_test_en  <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_win      <= w_win_nx;
            r_per      <= w_per_nx;
            r_code     <= w_code_nx;
            r_serr     <= w_serr_nx;
            r_pass     <= w_pass_nx;
            r_core_run <= (w_state_nx == ST_RUN);
            r_test_en  <= (w_state_nx == ST_BIST);
            r_halt     <= (w_state_nx == ST_HALT);
        end
    end

    assign core_run        = r_core_run;
    assign test_en_out     = r_test_en;
    assign halt            = r_halt;
    assign fault_code      = r_code;
    assign s_err_count     = r_serr;
    assign bist_pass_count = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_safety_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_safety_scheduler
// Description : Directed, table-driven self-checking bench for the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_safety_scheduler;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             loader_done_in;
    logic             hardware_fault_flag;
    logic             mux_error_flag;
    logic             s_err_imem, s_err_dmem;
    logic             d_err_imem, d_err_dmem;
    logic             clr_faults;
    logic             core_run, test_en_out, halt;
    logic [3:0]       fault_code;
    logic [CNT_W-1:0] s_err_count, bist_pass_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       ld, hw, mux, si, sd, di, dd, clr;
        logic       e_run, e_ten, e_hlt;
        logic [3:0] e_code;
        logic [7:0] e_serr, e_pass;
    } vec_t;

    vec_t vecs[$];

    pipeline_safety_scheduler #(
        .BIST_PERIOD (32),
        .BIST_LEN    (8),
        .SETTLE      (2),
        .CNT_W       (CNT_W),
        .SERR_LIMIT  (3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .loader_done_in      (loader_done_in),
        .hardware_fault_flag (hardware_fault_flag),
        .mux_error_flag      (mux_error_flag),
        .s_err_imem          (s_err_imem),
        .s_err_dmem          (s_err_dmem),
        .d_err_imem          (d_err_imem),
        .d_err_dmem          (d_err_dmem),
        .clr_faults          (clr_faults),
        .core_run            (core_run),
        .test_en_out         (test_en_out),
        .halt                (halt),
        .fault_code          (fault_code),
        .s_err_count         (s_err_count),
        .bist_pass_count     (bist_pass_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic er, input logic et, input logic eh,
                       input logic [3:0] ec, input logic [7:0] es, input logic [7:0] ep);
        n_tests++;
        if ({core_run, test_en_out, halt, fault_code, s_err_count, bist_pass_count} !==
            {er, et, eh, ec, es, ep}) begin
            n_fail++;
            $display("FAIL %s: got run=%0b ten=%0b halt=%0b code=%0d serr=%0d pass=%0d, expected run=%0b ten=%0b halt=%0b code=%0d serr=%0d pass=%0d",
                     name, core_run, test_en_out, halt, fault_code, s_err_count, bist_pass_count,
                     er, et, eh, ec, es, ep);
        end
    endtask

    // From BIST win 0: walk win 1..7, then land in RUN with the pass count bumped.
    task automatic through_bist(input int pass_now);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("bist_window", 0, 1, 0, 0, 0, 8'(pass_now));
        end
        step();
        chk("bist_to_run", 1, 0, 0, 0, 0, 8'(pass_now + 1));
    endtask

    // From RUN period 0: walk periods 1..31, then land in BIST win 0.
    task automatic through_run(input int pass_now);
        for (int i = 1; i < 32; i++) begin
            step();
            chk("run_period", 1, 0, 0, 0, 0, 8'(pass_now));
        end
        step();
        chk("run_to_bist", 0, 1, 0, 0, 0, 8'(pass_now));
    endtask

    function automatic vec_t mk(input logic ld, hw, mux, si, sd, di, dd, clr,
                                input logic r, t, h, input int c, s, p);
        vec_t v;
        v.ld = ld; v.hw = hw; v.mux = mux; v.si = si; v.sd = sd;
        v.di = di; v.dd = dd; v.clr = clr;
        v.e_run = r; v.e_ten = t; v.e_hlt = h;
        v.e_code = 4'(c); v.e_serr = 8'(s); v.e_pass = 8'(p);
        return v;
    endfunction

    initial begin
        // Table starts in RUN period 0 with pass count 4.
        //                  ld hw mx si sd di dd cl   run ten hlt code serr pass
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0,   0, 0, 1, 2, 0, 4));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0,   0, 0, 1, 2, 0, 4));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0,   0, 0, 1, 2, 0, 4));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 1, 2, 0, 4));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 4));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 5));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 5));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0,   0, 0, 1, 5, 3, 5));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 5));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 5));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 5));

        rst = 1'b1; loader_done_in = 1'b0; hardware_fault_flag = 1'b0;
        mux_error_flag = 1'b0; s_err_imem = 1'b0; s_err_dmem = 1'b0;
        d_err_imem = 1'b0; d_err_dmem = 1'b0; clr_faults = 1'b0;
        step();
        step();
        chk("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Errors are ignored while idle.
        d_err_imem = 1'b1; mux_error_flag = 1'b1; s_err_imem = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_ignore", 0, 0, 0, 0, 0, 0);
        end
        d_err_imem = 1'b0; mux_error_flag = 1'b0; s_err_imem = 1'b0;

        // Startup and two full BIST/RUN rounds.
        loader_done_in = 1'b1;
        step();
        chk("startup_bist", 0, 1, 0, 0, 0, 0);
        through_bist(0);
        through_run(1);
        through_bist(1);
        through_run(2);

        // Fault flag inside the settle interval is masked.
        step();
        hardware_fault_flag = 1'b1;
        step();
        hardware_fault_flag = 1'b0;
        chk("settle_mask", 0, 1, 0, 0, 0, 2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("settle_window", 0, 1, 0, 0, 0, 2);
        end
        step();
        chk("settle_pass", 1, 0, 0, 0, 0, 3);
        through_run(3);

        // Fault in the last window cycle halts instead of passing.
        for (int i = 0; i < 7; i++) begin
            step();
            chk("late_window", 0, 1, 0, 0, 0, 3);
        end
        hardware_fault_flag = 1'b1;
        step();
        hardware_fault_flag = 1'b0;
        chk("bist_fail_halt", 0, 0, 1, 4, 0, 3);
        step();
        chk("halt_hold", 0, 0, 1, 4, 0, 3);

        clr_faults = 1'b1;
        step();
        clr_faults = 1'b0;
        chk("clear_idle", 0, 0, 0, 0, 0, 3);
        step();
        chk("clear_bist", 0, 1, 0, 0, 0, 3);
        through_bist(3);

        foreach (vecs[i]) begin
            loader_done_in      = vecs[i].ld;
            hardware_fault_flag = vecs[i].hw;
            mux_error_flag      = vecs[i].mux;
            s_err_imem          = vecs[i].si;
            s_err_dmem          = vecs[i].sd;
            d_err_imem          = vecs[i].di;
            d_err_dmem          = vecs[i].dd;
            clr_faults          = vecs[i].clr;
            step();
            chk($sformatf("vec%0d", i), vecs[i].e_run, vecs[i].e_ten, vecs[i].e_hlt,
                vecs[i].e_code, vecs[i].e_serr, vecs[i].e_pass);
        end
        hardware_fault_flag = 1'b0; mux_error_flag = 1'b0; s_err_imem = 1'b0;
        s_err_dmem = 1'b0; d_err_imem = 1'b0; d_err_dmem = 1'b0; clr_faults = 1'b0;
        loader_done_in = 1'b1;

        // Reload request mid-RUN.
        through_bist(5);
        step();
        chk("run_mid", 1, 0, 0, 0, 0, 6);
        loader_done_in = 1'b0;
        step();
        chk("reload_idle", 0, 0, 0, 0, 0, 6);
        loader_done_in = 1'b1;
        step();
        chk("reload_bist", 0, 1, 0, 0, 0, 6);
        through_bist(6);

        // Fatal fault beats a simultaneous loader drop.
        loader_done_in = 1'b0; mux_error_flag = 1'b1;
        step();
        mux_error_flag = 1'b0;
        chk("fatal_over_reload", 0, 0, 1, 3, 0, 7);
        clr_faults = 1'b1;
        step();
        clr_faults = 1'b0;
        chk("clear_no_loader", 0, 0, 0, 0, 0, 7);
        step();
        chk("idle_wait", 0, 0, 0, 0, 0, 7);

        // Reset mid-window clears everything.
        loader_done_in = 1'b1;
        step();
        step();
        step();
        chk("pre_reset_bist", 0, 1, 0, 0, 0, 7);
        rst = 1'b1;
        step();
        chk("reset_mid_bist", 0, 0, 0, 0, 0, 0);
        rst = 1'b0; loader_done_in = 1'b0;
        step();
        chk("post_reset_idle", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_safety_scheduler.md
# pipeline_safety_scheduler

Run-time sequencer that sits beside the pipelined core and owns its safety resources. It holds the core idle until the instruction loader finishes, then runs a startup ALU BIST window. It then alternates normal execution with periodic BIST windows, driving the core's `test_en_in`. It also monitors the ECC and mux-error flags, counts correctable errors and latches the first fatal condition into a halt state with a fault code.

## Interface
- `BIST_PERIOD`, default 1024: RUN cycles between BIST windows; must be ≥ 2.
- `BIST_LEN`, default 16: cycles per BIST window; must be ≥ 2.
- `SETTLE`, default 4: first cycles of each window during which `hardware_fault_flag` is ignored; must be < `BIST_LEN`.
- `CNT_W`, default 8: width of the error and pass counters.
- `SERR_LIMIT`, default 16: single-bit ECC error budget; 1 ≤ `SERR_LIMIT` ≤ 2^`CNT_W`−1.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `loader_done_in` in 1: the program image is loaded into IMEM.
- `hardware_fault_flag` in 1: ALU BIST mismatch from the core.
- `mux_error_flag` in 1: PC-select or writeback mux error.
- `s_err_imem`, `s_err_dmem` in 1 each: corrected single-bit ECC errors.
- `d_err_imem`, `d_err_dmem` in 1 each: uncorrectable double-bit ECC errors.
- `clr_faults` in 1: software or debug acknowledge that leaves HALT.
- `core_run` out 1: pipeline enable (clock-enable / stall release).
- `test_en_out` out 1: drives the core's `test_en_in`.
- `halt` out 1: a fatal fault is latched.
- `fault_code` out 4: 0 none, 1 `d_err_imem`, 2 `d_err_dmem`, 3 mux error, 4 ALU BIST fail, 5 single-error limit reached.
- `s_err_count` out `CNT_W`: saturating count of single-bit errors.
- `bist_pass_count` out `CNT_W`: count of passed BIST windows; wraps modulo 2^`CNT_W`.

## Operation
- **Outputs.** All outputs are registered.
  - `core_run` = (state == RUN).
  - `test_en_out` = (state == BIST).
  - `halt` = (state == HALT).
- **States.** There are four: IDLE, BIST, RUN, HALT.
  - `rst` → IDLE. The window and period counters, `fault_code`, `s_err_count` and `bist_pass_count` all reset to 0, as do all outputs.
- **IDLE.** Every error input is ignored.
  - `loader_done_in` = 1 → BIST, with the window counter at 0.
- **BIST.** The window counter `win` runs from 0 to `BIST_LEN`−1.
  - `hardware_fault_flag` = 1 with `win` ≥ `SETTLE` is a fatal fault with code 4.
  - At `win` = `BIST_LEN`−1 with no fatal fault → RUN. `bist_pass_count` increments and the period counter clears.
- **RUN.** The period counter runs from 0 to `BIST_PERIOD`−1, then → BIST with `win` = 0.
  - `hardware_fault_flag` is ignored in RUN.
  - `loader_done_in` = 0 → IDLE (reload). This also applies in BIST. A fatal fault in the same cycle takes priority.
- **Fatal faults** are detected only in BIST and RUN.
  - `d_err_imem`, `d_err_dmem` or `mux_error_flag` → HALT.
  - `s_err_count` reaching ≥ `SERR_LIMIT` after the update → HALT with code 5.
  - Several fatal sources in one cycle: the lowest nonzero code is latched.
  - `fault_code` is written only on entry to HALT and holds until cleared.
- **Single-bit error counting** happens only in BIST and RUN.
  - Each asserted `s_err_*` adds 1, so both in one cycle adds 2.
  - The count saturates at 2^`CNT_W`−1.
- **HALT.** All error inputs are ignored.
  - `clr_faults` = 1 → IDLE, clearing `fault_code` and `s_err_count`. `bist_pass_count` is preserved.
  - If `loader_done_in` is still 1, the scheduler then proceeds to BIST on the following edge.
- `clr_faults` outside HALT has no effect.

## Timing
- An input sampled at edge k takes effect in the outputs after edge k; there is no combinational input-to-output path.
- `loader_done_in` high at edge k: `test_en_out` = 1 from k+1 to k+`BIST_LEN`, and `core_run` = 1 from k+`BIST_LEN`+1.
- A fault-free BIST window lasts exactly `BIST_LEN` cycles.
- A RUN interval lasts exactly `BIST_PERIOD` cycles.
- `test_en_out` and `core_run` are never high together, and are never high in the same cycle as `halt`.
- A fault in the last BIST cycle goes to HALT, not RUN, and `bist_pass_count` does not increment.
- Fatal input at edge k: `halt` = 1, `core_run` = 0 and `fault_code` are valid after edge k.
- `rst` wins over every other input in any state, including mid-window.

## Test plan
All scenarios use `BIST_PERIOD`=32, `BIST_LEN`=8, `SETTLE`=2, `SERR_LIMIT`=3, `CNT_W`=8.

1. **Startup.** Reset, then raise `loader_done_in` at cycle 5 with no faults.
   - Required: `test_en_out` high for cycles 6–13, then `core_run` high for 32 cycles.
   - Required: BIST repeats; `bist_pass_count` = 1, then 2.
2. **Settle masking.** Pulse `hardware_fault_flag` at `win` = 1 → ignored and the window passes.
   - Pulse it at `win` = 7 → `halt` = 1, `fault_code` = 4, `bist_pass_count` unchanged.
3. **Priority.** In RUN, assert `d_err_dmem` and `mux_error_flag` together → `fault_code` = 2.
   - Then toggle all error inputs while in HALT → no output changes.
4. **ECC budget.** In RUN, assert `s_err_imem` alone, then `s_err_imem` and `s_err_dmem` together.
   - Required: `s_err_count` = 1, then 3; `halt` with `fault_code` = 5 after the second edge.
5. **Recovery.** From HALT, assert `clr_faults` with `loader_done_in` = 1.
   - Required: IDLE for one cycle, then BIST, with `fault_code` = 0, `s_err_count` = 0 and `bist_pass_count` retained.
6. **Reload and reset.**
   - Drop `loader_done_in` mid-RUN → IDLE and `core_run` = 0 next cycle.
   - Assert `rst` mid-BIST → every output and counter is 0 next cycle.
